// File: rtl/apb_master_arbiter_if.sv
// Bundle of the two requester ports and the shared APB3 bus.
// The arbiter connects through the master modport. The requesters and the
// APB slave connect through the slave modport.
interface apb_master_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // requester 0 (frame engine)
  logic              req0_valid;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic [STRB_W-1:0] req0_strb;
  logic              req0_done;
  logic [DATA_W-1:0] req0_rdata;
  logic              req0_err;

  // requester 1 (host/debug)
  logic              req1_valid;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic [STRB_W-1:0] req1_strb;
  logic              req1_done;
  logic [DATA_W-1:0] req1_rdata;
  logic              req1_err;

  // APB3
  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [STRB_W-1:0] PSTRB;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  req0_valid, req0_write, req0_addr, req0_wdata, req0_strb,
    input  req1_valid, req1_write, req1_addr, req1_wdata, req1_strb,
    output req0_done, req0_rdata, req0_err,
    output req1_done, req1_rdata, req1_err,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    output req0_valid, req0_write, req0_addr, req0_wdata, req0_strb,
    output req1_valid, req1_write, req1_addr, req1_wdata, req1_strb,
    input  req0_done, req0_rdata, req0_err,
    input  req1_done, req1_rdata, req1_err,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_master_arbiter.sv
// Two-requester round-robin APB3 master.
// Requester 0 is the Modbus frame engine and requester 1 is the host/debug port.
// The block runs IDLE -> SETUP -> ACCESS -> DONE. Every output is registered.
// After each completed access the winning requester gets a one-cycle done pulse.
// Optional build macro APB_ARB_TIMEOUT_EN adds an ACCESS-phase wait timeout.
// When a transfer times out, it is aborted with err=1 and rdata=0.
module apb_master_arbiter #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  apb_master_arbiter_if.master bus
);
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  // A timeout of zero cycles would abort every access before it starts.
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout_cfg
    $error("apb_master_arbiter: TIMEOUT_CYC must be at least 1");
  end

  state_t                   state;
  logic                     gnt;         // requester owning the current transfer
  logic                     last_grant;  // loses the next tie
  logic [1:0]               vld;
  logic [1:0]               done_q;
  logic [1:0]               err_q;
  logic [1:0][DATA_W-1:0]   rdata_q;

  logic                     sel_nxt;
  logic                     nxt_write;
  logic [ADDR_W-1:0]        nxt_addr;
  logic [DATA_W-1:0]        nxt_wdata;
  logic [STRB_W-1:0]        nxt_strb;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;
`endif

  assign vld = {bus.req1_valid, bus.req0_valid};

  // Round-robin pick. Only the winner's request fields are ever forwarded.
  always_comb begin
    sel_nxt   = (vld == 2'b11) ? ~last_grant : vld[1];
    nxt_write = sel_nxt ? bus.req1_write : bus.req0_write;
    nxt_addr  = sel_nxt ? bus.req1_addr  : bus.req0_addr;
    nxt_wdata = sel_nxt ? bus.req1_wdata : bus.req0_wdata;
    nxt_strb  = sel_nxt ? bus.req1_strb  : bus.req0_strb;
  end

  // Transfer sequencer: grant, APB phases, response capture, done pulse.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      last_grant  <= 1'b1;
      done_q      <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
      bus.PADDR   <= '0;
      bus.PSEL    <= 1'b0;
      bus.PENABLE <= 1'b0;
      bus.PWRITE  <= 1'b0;
      bus.PWDATA  <= '0;
      bus.PSTRB   <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      done_q <= '0;
      case (state)
        IDLE: begin
          if (|vld) begin
            gnt        <= sel_nxt;
            last_grant <= sel_nxt;
            bus.PADDR  <= nxt_addr;
            bus.PWRITE <= nxt_write;
            bus.PWDATA <= nxt_wdata;
            bus.PSTRB  <= nxt_write ? nxt_strb : '0;
            bus.PSEL   <= 1'b1;
            state      <= SETUP;
          end
        end
        SETUP: begin
          bus.PENABLE <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
          wait_cnt    <= '0;
`endif
          state       <= ACCESS;
        end
        ACCESS: begin
          // PREADY takes priority over a timeout in the same cycle.
          if (bus.PREADY) begin
            if (!bus.PWRITE) rdata_q[gnt] <= bus.PRDATA;
            err_q[gnt]  <= bus.PSLVERR;
            done_q[gnt] <= 1'b1;
            bus.PSEL    <= 1'b0;
            bus.PENABLE <= 1'b0;
            state       <= DONE;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            rdata_q[gnt] <= '0;
            err_q[gnt]   <= 1'b1;
            done_q[gnt]  <= 1'b1;
            bus.PSEL     <= 1'b0;
            bus.PENABLE  <= 1'b0;
            state        <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          // Requester valid is ignored here so it can drop or refresh.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req0_done  = done_q[0];
  assign bus.req1_done  = done_q[1];
  assign bus.req0_rdata = rdata_q[0];
  assign bus.req1_rdata = rdata_q[1];
  assign bus.req0_err   = err_q[0];
  assign bus.req1_err   = err_q[1];

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter.
// A transaction-level reference model checks every output on every cycle.
// Directed scenarios add hand-computed latency, order and data checks.
module tb_apb_master_arbiter;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int TO     = 8;

  logic PCLK   = 1'b0;
  logic PRESET = 1'b1;
  always #5 PCLK = ~PCLK;

  apb_master_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_master_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, want 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // The model tracks the transfer as "cycles since grant". The bus is free
  // again two edges after the completion edge.
  bit                started = 0;
  bit                m_busy  = 0;
  bit                m_owner = 0;
  bit                m_last  = 1;
  int                m_start = 0;
  int                m_free  = 0;
  logic              e_psel, e_pen, e_write;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_wdata;
  logic [STRB_W-1:0] e_strb;
  logic [1:0]        e_done, e_err;
  logic [DATA_W-1:0] e_rdata [2];

  task automatic m_finish(input bit abort);
    e_psel = 0; e_pen = 0;
    e_done[m_owner] = 1'b1;
    if (abort) begin
      e_rdata[m_owner] = '0; e_err[m_owner] = 1'b1;
    end else begin
      if (!e_write) e_rdata[m_owner] = bus.PRDATA;
      e_err[m_owner] = bus.PSLVERR;
    end
    m_busy = 0;
    m_free = cyc + 2;
  endtask

  task automatic model_step();
    int t;
    if (PRESET) begin
      started = 1; m_busy = 0; m_last = 1; m_free = cyc + 1;
      e_psel = 0; e_pen = 0; e_write = 0; e_addr = '0; e_wdata = '0; e_strb = '0;
      e_done = '0; e_err = '0; e_rdata[0] = '0; e_rdata[1] = '0;
      return;
    end
    if (!started) return;
    e_done = '0;
    if (!m_busy) begin
      if (cyc >= m_free && (bus.req0_valid || bus.req1_valid)) begin
        m_owner = (bus.req0_valid && bus.req1_valid) ? !m_last : bus.req1_valid;
        m_last  = m_owner;
        if (m_owner) begin
          e_write = bus.req1_write; e_addr = bus.req1_addr; e_wdata = bus.req1_wdata;
          e_strb  = bus.req1_write ? bus.req1_strb : '0;
        end else begin
          e_write = bus.req0_write; e_addr = bus.req0_addr; e_wdata = bus.req0_wdata;
          e_strb  = bus.req0_write ? bus.req0_strb : '0;
        end
        e_psel = 1; e_pen = 0; m_busy = 1; m_start = cyc;
      end
    end else begin
      t = cyc - m_start;
      if (t == 1) e_pen = 1;
      else if (bus.PREADY) m_finish(1'b0);
`ifdef APB_ARB_TIMEOUT_EN
      else if (t - 1 == TO) m_finish(1'b1);
`endif
    end
  endtask

  initial forever begin
    @(posedge PCLK);
    cyc++;
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge PCLK);
    if (started) begin
      chk("PSEL",       32'(bus.PSEL),       32'(e_psel));
      chk("PENABLE",    32'(bus.PENABLE),    32'(e_pen));
      chk("PWRITE",     32'(bus.PWRITE),     32'(e_write));
      chk("PADDR",      32'(bus.PADDR),      32'(e_addr));
      chk("PWDATA",     bus.PWDATA,          e_wdata);
      chk("PSTRB",      32'(bus.PSTRB),      32'(e_strb));
      chk("req0_done",  32'(bus.req0_done),  32'(e_done[0]));
      chk("req1_done",  32'(bus.req1_done),  32'(e_done[1]));
      chk("req0_rdata", bus.req0_rdata,      e_rdata[0]);
      chk("req1_rdata", bus.req1_rdata,      e_rdata[1]);
      chk("req0_err",   32'(bus.req0_err),   32'(e_err[0]));
      chk("req1_err",   32'(bus.req1_err),   32'(e_err[1]));
      chk("done_overlap", 32'(bus.req0_done & bus.req1_done), 32'd0);
    end
  end

  // ---------------- event monitor ----------------
  int psel_rise [$];
  int pen_rise  [$];
  int pen_fall  [$];
  int done_order[$];
  bit p_psel = 0, p_pen = 0;

  initial forever begin
    @(negedge PCLK);
    if (started) begin
      if (bus.PSEL && !p_psel)    psel_rise.push_back(cyc);
      if (bus.PENABLE && !p_pen)  pen_rise.push_back(cyc);
      if (!bus.PENABLE && p_pen)  pen_fall.push_back(cyc);
      if (bus.req0_done)          done_order.push_back(0);
      if (bus.req1_done)          done_order.push_back(1);
      p_psel = bus.PSEL;
      p_pen  = bus.PENABLE;
    end
  end

  // ---------------- APB slave ----------------
  // PREADY is held low for the first wait_n ACCESS cycles of each transfer.
  int          wait_n  = 0;
  logic [31:0] rd_val  = 32'h0;
  bit          err_val = 0;

  initial begin
    int acc;
    acc = 0;
    bus.PREADY = 0; bus.PRDATA = '0; bus.PSLVERR = 0;
    forever begin
      @(negedge PCLK);
      if (bus.PSEL && bus.PENABLE) begin
        bus.PREADY  = (acc >= wait_n);
        bus.PRDATA  = bus.PREADY ? rd_val : 32'h0;
        bus.PSLVERR = bus.PREADY ? err_val : 1'b0;
        acc++;
      end else begin
        acc = 0; bus.PREADY = 0; bus.PRDATA = '0; bus.PSLVERR = 0;
      end
    end
  end

  // ---------------- requester drivers ----------------
  task automatic set_req(input int r, input bit v, input bit w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
    if (r == 0) begin
      bus.req0_valid = v; bus.req0_write = w; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_strb = s;
    end else begin
      bus.req1_valid = v; bus.req1_write = w; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_strb = s;
    end
  endtask

  // Issue one transfer and hold valid until done is seen.
  // Returns the cycle valid was raised and the cycle done was seen.
  task automatic xfer(input int r, input bit w, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s,
                      output int vcyc, output int dcyc);
    bit seen;
    seen = 0;
    dcyc = -1;
    set_req(r, 1'b1, w, a, d, s);
    vcyc = cyc;
    for (int i = 0; i < 300; i++) begin
      @(negedge PCLK); #1;
      if ((r == 0 && bus.req0_done) || (r == 1 && bus.req1_done)) begin
        seen = 1; dcyc = cyc; break;
      end
    end
    if (r == 0) bus.req0_valid = 0; else bus.req1_valid = 0;
    chk($sformatf("done_seen_req%0d", r), 32'(seen), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge PCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int v, d, snap, n, ok;
    set_req(0, 0, 0, '0, '0, '0);
    set_req(1, 0, 0, '0, '0, '0);
    idle(2);
    chk("rst_PSEL",    32'(bus.PSEL),    32'd0);
    chk("rst_PENABLE", 32'(bus.PENABLE), 32'd0);
    chk("rst_PWDATA",  bus.PWDATA,       32'd0);
    chk("rst_done0",   32'(bus.req0_done), 32'd0);
    chk("rst_rdata1",  bus.req1_rdata,   32'd0);
    PRESET = 0;
    idle(1);

    // 1: single zero-wait write
    wait_n = 0;
    xfer(0, 1, 12'h000, 32'hDEADBEEF, 4'hF, v, d);
    chk("t1_psel_lat", 32'(psel_rise[psel_rise.size()-1] - v), 32'd1);
    chk("t1_pen_lat",  32'(pen_rise[pen_rise.size()-1] - v),   32'd2);
    chk("t1_done_lat", 32'(d - v), 32'd3);
    chk("t1_pwdata",   bus.PWDATA, 32'hDEADBEEF);
    chk("t1_pstrb",    32'(bus.PSTRB), 32'hF);
    chk("t1_err",      32'(bus.req0_err), 32'd0);
    idle(2);

    // 2: read with three wait states
    wait_n = 3; rd_val = 32'hA5A55A5A;
    snap = done_order.size();
    xfer(1, 0, 12'h004, 32'h0, 4'hF, v, d);
    chk("t2_pen_len",  32'(pen_fall[pen_fall.size()-1] - pen_rise[pen_rise.size()-1]), 32'd4);
    chk("t2_done_lat", 32'(d - v), 32'd6);
    chk("t2_pstrb",    32'(bus.PSTRB), 32'd0);
    idle(3);
    chk("t2_rdata_hold", bus.req1_rdata, 32'hA5A55A5A);
    chk("t2_done_once",  32'(done_order.size() - snap), 32'd1);

    // 3: contention, both requesters valid for two transfers each
    wait_n = 0; rd_val = 32'h11223344;
    snap = done_order.size();
    fork
      begin
        int v0, d0;
        xfer(0, 1, 12'h010, 32'h00000010, 4'h3, v0, d0);
        xfer(0, 1, 12'h014, 32'h00000014, 4'hC, v0, d0);
      end
      begin
        int v1, d1;
        xfer(1, 0, 12'h020, 32'h0, 4'hF, v1, d1);
        xfer(1, 0, 12'h024, 32'h0, 4'hF, v1, d1);
      end
    join
    chk("t3_ndone", 32'(done_order.size() - snap), 32'd4);
    if (done_order.size() - snap == 4) begin
      chk("t3_order0", 32'(done_order[snap]),   32'd0);
      chk("t3_order1", 32'(done_order[snap+1]), 32'd1);
      chk("t3_order2", 32'(done_order[snap+2]), 32'd0);
      chk("t3_order3", 32'(done_order[snap+3]), 32'd1);
    end
    n = psel_rise.size();
    for (int i = n - 3; i < n; i++)
      chk($sformatf("t3_psel_gap%0d", i - n + 3), 32'(psel_rise[i] - psel_rise[i-1]), 32'd4);
    idle(2);

    // 4: slave error on read, then a clean write clears it
    rd_val = 32'h0BADF00D; err_val = 1;
    xfer(0, 0, 12'h008, 32'h0, 4'hF, v, d);
    chk("t4_err_set", 32'(bus.req0_err), 32'd1);
    err_val = 0;
    xfer(0, 1, 12'h00C, 32'hCAFE0001, 4'h1, v, d);
    chk("t4_err_clr",    32'(bus.req0_err), 32'd0);
    chk("t4_rdata_keep", bus.req0_rdata, 32'h0BADF00D);
    idle(2);

    // 5: reset while ACCESS is waiting on PREADY
    wait_n = 1000;
    set_req(0, 1, 0, 12'h030, 32'h0, 4'h0);
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge PCLK); #1;
      if (bus.PENABLE) begin ok = 1; break; end
    end
    chk("t5_in_access", 32'(ok), 32'd1);
    idle(1);
    snap = done_order.size();
    PRESET = 1;
    bus.req0_valid = 0;
    idle(1);
    chk("t5_psel",  32'(bus.PSEL),      32'd0);
    chk("t5_pen",   32'(bus.PENABLE),   32'd0);
    chk("t5_rdata", bus.req0_rdata,     32'd0);
    chk("t5_err",   32'(bus.req0_err),  32'd0);
    PRESET = 0;
    idle(3);
    chk("t5_no_done", 32'(done_order.size() - snap), 32'd0);
    wait_n = 0;
    fork
      begin int va, da; xfer(0, 1, 12'h040, 32'h40, 4'hF, va, da); end
      begin int vb, db; xfer(1, 1, 12'h044, 32'h44, 4'hF, vb, db); end
    join
    if (done_order.size() - snap >= 1)
      chk("t5_tie_req0", 32'(done_order[snap]), 32'd0);
    else
      chk("t5_tie_ndone", 32'(done_order.size() - snap), 32'd2);
    idle(2);

`ifdef APB_ARB_TIMEOUT_EN
    // 6: timeout abort, then PREADY on the last wait cycle wins
    wait_n = 1000; rd_val = 32'h77777777;
    xfer(0, 0, 12'h050, 32'h0, 4'hF, v, d);
    chk("t6_to_err",   32'(bus.req0_err), 32'd1);
    chk("t6_to_rdata", bus.req0_rdata,    32'd0);
    chk("t6_to_len",   32'(pen_fall[pen_fall.size()-1] - pen_rise[pen_rise.size()-1]), 32'd8);
    idle(2);
    wait_n = 7;
    xfer(0, 0, 12'h054, 32'h0, 4'hF, v, d);
    chk("t6_ok_err",   32'(bus.req0_err), 32'd0);
    chk("t6_ok_rdata", bus.req0_rdata,    32'h77777777);
    idle(2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
